// File: rtl/led_fader.sv
// led_fader: PWM LED driver with linear fade-in/fade-out ramp.
// Ports: clk_i, rst_ni, level_i in; pwm_o, bright_o, busy_o out. Macro LED_FADER_GAMMA_EN.
module led_fader #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 1000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                level_i,
  output logic                pwm_o,
  output logic [PWM_BITS-1:0] bright_o,
  output logic                busy_o
);

  localparam int MAX_I = (1 << PWM_BITS) - 1;
  localparam int PSW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(MAX_I);
  localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] ZERO = '0;
  localparam logic [PSW-1:0] PS_LAST = PSW'(STEP_DIV - 1);

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_RISE = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_FALL = 2'd3;

  logic [1:0]          state;
  logic [1:0]          state_n;
  logic [PWM_BITS-1:0] bright;
  logic [PWM_BITS-1:0] bright_n;
  logic [PSW-1:0]      presc;
  logic [PSW-1:0]      presc_n;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] duty_src;
  logic                pwm_q;
  logic                busy;
  logic                fading;
  logic                step;
  logic                fading_n;
  logic                wrap;

  assign fading = (state == S_RISE) || (state == S_FALL);
  assign step = fading && (presc == PS_LAST);
  assign fading_n = (state_n == S_RISE) || (state_n == S_FALL);
  assign wrap = (pwm_cnt == MAX - ONE);

  // Reversals keep brightness; the ramp ends clamped at 0 or MAX
  // even if a reversal left it already sitting at the end value.
  always_comb begin
    state_n = state;
    bright_n = bright;
    unique case (1'b1)
      (state == S_OFF): begin
        if (level_i) state_n = S_RISE;
      end
      (state == S_RISE): begin
        if (!level_i) begin
          state_n = S_FALL;
        end else if (step) begin
          if (bright >= MAX - ONE) begin
            bright_n = MAX;
            state_n = S_ON;
          end else begin
            bright_n = bright + ONE;
          end
        end
      end
      (state == S_ON): begin
        if (!level_i) state_n = S_FALL;
      end
      (state == S_FALL): begin
        if (level_i) begin
          state_n = S_RISE;
        end else if (step) begin
          if (bright <= ONE) begin
            bright_n = ZERO;
            state_n = S_OFF;
          end else begin
            bright_n = bright - ONE;
          end
        end
      end
      default: state_n = S_OFF;
    endcase
  end

  // Prescaler restarts on any transition so the first step lands
  // a full STEP_DIV cycles after entering a fade.
  always_comb begin
    presc_n = '0;
    if (fading && (state_n == state) && (presc != PS_LAST))
      presc_n = presc + 1'b1;
  end

`ifdef LED_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  assign sq = {{PWM_BITS{1'b0}}, bright} * {{PWM_BITS{1'b0}}, bright}
            + {{PWM_BITS{1'b0}}, MAX};
  assign duty_src = PWM_BITS'(sq >> PWM_BITS);
`else
  assign duty_src = bright;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_OFF;
      bright <= '0;
      presc <= '0;
      busy <= 1'b0;
      pwm_cnt <= '0;
      duty <= '0;
      pwm_q <= 1'b0;
    end else begin
      state <= state_n;
      bright <= bright_n;
      presc <= presc_n;
      busy <= fading_n;
      pwm_cnt <= wrap ? ZERO : pwm_cnt + ONE;
      if (wrap) duty <= duty_src;
      pwm_q <= (pwm_cnt < duty);
    end
  end

  assign pwm_o = pwm_q;
  assign bright_o = bright;
  assign busy_o = busy;

endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: random + directed bench for led_fader.
// Checks against a fade/PWM reference model every cycle.
module tb_led_fader;
  localparam int PB = 4;
  localparam int SD = 4;
  localparam int MAXV = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic level = 1'b0;
  logic pwm;
  logic [PB-1:0] bright;
  logic busy;

  always #5 clk = ~clk;

  led_fader #(.PWM_BITS(PB), .STEP_DIV(SD)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .level_i(level),
    .pwm_o(pwm),
    .bright_o(bright),
    .busy_o(busy)
  );

  int total = 0;
  int bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int gam(int b);
`ifdef LED_FADER_GAMMA_EN
    return (b * b + MAXV) / (MAXV + 1);
`else
    return b;
`endif
  endfunction

  // Reference: brightness moves one unit per SD cycles toward the
  // level's target; a change of level restarts the wait. PWM phase
  // is edge count since reset modulo MAXV.
  int m_b = 0;
  int m_dir = 0;
  int m_el = 0;
  int m_t = 0;
  int m_duty = 0;
  int m_pwm = 0;
  int want, tgt, pos, ob;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_b = 0; m_dir = 0; m_el = 0;
      m_t = 0; m_duty = 0; m_pwm = 0;
    end else begin
      ob = m_b;
      pos = m_t % MAXV;
      m_pwm = (pos < m_duty) ? 1 : 0;
      if (pos == MAXV - 1) m_duty = gam(ob);
      m_t++;
      want = level ? 1 : -1;
      tgt = level ? MAXV : 0;
      if (m_dir == 0) begin
        if (m_b != tgt) begin
          m_dir = want;
          m_el = 0;
        end
      end else if (m_dir != want) begin
        m_dir = want;
        m_el = 0;
      end else begin
        m_el++;
        if (m_el == SD) begin
          m_el = 0;
          m_b = m_b + m_dir;
          if (m_b > MAXV) m_b = MAXV;
          if (m_b < 0) m_b = 0;
          if (m_b == tgt) m_dir = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("bright", bright, m_b);
    check("busy", busy, (m_dir != 0) ? 1 : 0);
    check("pwm", pwm, m_pwm);
  end

  task automatic wait_bright(int v, int lim, string name);
    int n = 0;
    while (bright !== PB'(v) && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(name, bright, v);
  endtask

  task automatic count_hi(output int hi);
    hi = 0;
    repeat (15) begin
      @(negedge clk);
      hi += int'(pwm);
    end
  endtask

  int hi;
  int prev;
  int n;
  int exp5;

  initial begin
    level = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pwm", pwm, 0);
    check("rst_bright", bright, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    for (int k = 0; k <= 60; k++) begin
      @(negedge clk);
      if (k == 0) check("busy_edge0", busy, 1);
      if (k == 3) check("bright_k3", bright, 0);
      if (k == 4) check("bright_k4", bright, 1);
      if (k == 59) check("bright_k59", bright, 14);
      if (k == 60) begin
        check("on_bright", bright, 15);
        check("on_busy", busy, 0);
      end
    end
    repeat (30) @(negedge clk);
    count_hi(hi);
    check("pwm_full", hi, 15);

    level = 1'b0;
    wait_bright(0, 100, "fall_to0");
    repeat (30) @(negedge clk);
    count_hi(hi);
    check("pwm_zero", hi, 0);

    level = 1'b1;
    wait_bright(6, 100, "rise_to6");
    level = 1'b0;
    prev = 6;
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
      if (int'(bright) != prev) begin
        check("rev_step", bright, prev - 1);
        prev = int'(bright);
      end
    end
    check("rev_end_bright", bright, 0);
    check("rev_end_busy", busy, 0);

    level = 1'b1;
    wait_bright(5, 100, "rise_to5");
    level = 1'b0;
    repeat (40) begin
      @(negedge clk);
      level = ~level;
    end
`ifdef LED_FADER_GAMMA_EN
    exp5 = 2;
`else
    exp5 = 5;
`endif
    hi = 0;
    repeat (15) begin
      @(negedge clk);
      level = ~level;
      hi += int'(pwm);
    end
    check("duty5", hi, exp5);
    check("hold5", bright, 5);

    level = 1'b1;
    wait_bright(12, 100, "rise_to12");
    level = 1'b0;
    wait_bright(9, 100, "fall_to9");
    #2 rst_n = 1'b0;
    #1;
    check("async_pwm", pwm, 0);
    check("async_bright", bright, 0);
    check("async_busy", busy, 0);
    @(negedge clk);
    level = 1'b0;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_bright", bright, 0);
    check("post_rst_busy", busy, 0);

    repeat (300) begin
      level = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) n = $urandom_range(40, 80);
      else n = $urandom_range(1, 10);
      repeat (n) @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
